// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction fetch unit with a single outstanding memory request
//            and a small FIFO of {instruction, pc} entries feeding decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        soc_clk,
    input  logic        IDU_reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        IDU_stall,
    output logic        Fetch_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);

    localparam int unsigned   PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW        = PW + 1;
    localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
    localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
    localparam logic [PW-1:0] C_PTR_ONE = PW'(1);
    localparam logic [31:0]   C_NOP     = 32'h0000_0013;
    localparam logic [31:0]   C_PC_STEP = 32'd4;

    logic [31:0]   r_word [DEPTH];
    logic [31:0]   r_pc   [DEPTH];
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_pending;
    logic          r_drop;
    logic          r_fault;

    logic          w_ready;
    logic          w_issue;
    logic          w_resp;
    logic          w_push;
    logic          w_pop;
    logic          w_misaligned;

    assign w_ready      = (r_count != '0);
    // A free slot is guaranteed for the response because only one request is ever in flight
    assign w_issue      = ~r_pending & ~r_fault & ~redirect_valid & ~IDU_reset
                          & (r_count < C_DEPTH);
    assign w_resp       = mem_rvalid & r_pending;
    assign w_push       = w_resp & ~r_drop & ~redirect_valid;
    assign w_pop        = w_ready & ~IDU_stall & ~redirect_valid;
    assign w_misaligned = (redirect_pc[1:0] != 2'b00);

    // Request tracking: fetch address, outstanding request and stale-response drop
    always_ff @(posedge soc_clk or posedge IDU_reset) begin
        if (IDU_reset) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_pending  <= 1'b0;
            r_drop     <= 1'b0;
            r_fault    <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_fault    <= w_misaligned;
            if (mem_rvalid) begin
                r_pending <= 1'b0;
                r_drop    <= 1'b0;
            end else if (r_pending) begin
                r_drop    <= 1'b1;
            end
        end else if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + C_PC_STEP;
            r_req_pc   <= r_fetch_pc;
            r_pending  <= 1'b1;
        end else if (w_resp) begin
            r_pending  <= 1'b0;
            r_drop     <= 1'b0;
        end
    end

    // Queue bookkeeping; a redirect flushes everything and wins over push/pop
    always_ff @(posedge soc_clk or posedge IDU_reset) begin
        if (IDU_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + C_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - C_CNT_ONE;
            end
        end
    end

    always_ff @(posedge soc_clk) begin
        if (w_push) begin
            r_word[r_wr_ptr] <= mem_rdata;
            r_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

    assign mem_req     = w_issue;
    assign mem_addr    = r_fetch_pc;
    assign Fetch_ready = w_ready;
    assign instruction = w_ready ? r_word[r_rd_ptr] : C_NOP;
    assign instr_pc    = w_ready ? r_pc[r_rd_ptr]   : 32'h0000_0000;
    assign fetch_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Directed self-checking bench for fetch_queue with a tagged memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        Fetch_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] iss_q[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_ins[$];

    int          mem_lat = 1;
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_a = '0;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH   (4),
        .RESET_PC(RESET_PC)
    ) dut (
        .soc_clk       (clk),
        .IDU_reset     (rst),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .IDU_stall     (stall),
        .Fetch_ready   (Fetch_ready),
        .instruction   (instruction),
        .instr_pc      (instr_pc),
        .fetch_fault   (fetch_fault)
    );

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: answers each request after mem_lat cycles with tag(addr)
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_rvalid = 1'b0;
            if (rst) begin
                mem_busy = 1'b0;
            end else if (mem_busy) begin
                mem_cnt = mem_cnt - 1;
                if (mem_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = tag(mem_a);
                    mem_busy   = 1'b0;
                end
            end
            #2;
            if (!mem_busy && mem_req) begin
                mem_busy = 1'b1;
                mem_a    = mem_addr;
                mem_cnt  = mem_lat;
                iss_q.push_back(mem_addr);
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic observe(input int n);
        repeat (n) begin
            @(negedge clk);
            if (Fetch_ready && !stall && !redirect_valid) begin
                pop_pc.push_back(instr_pc);
                pop_ins.push_back(instruction);
            end
        end
    endtask

    task automatic wait_iss(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (iss_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
        checks++; if (Fetch_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", Fetch_ready); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b want 0", fetch_fault); end
        checks++; if (instruction !== NOP) begin errors++; $display("FAIL rst_instr got %h want %h", instruction, NOP); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", instr_pc); end
        checks++; if (mem_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr got %h want %h", mem_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        drive_edge();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", mem_req); end
        checks++; if (mem_addr !== RESET_PC) begin errors++; $display("FAIL first_addr got %h want %h", mem_addr, RESET_PC); end
        @(negedge clk);
        checks++; if (Fetch_ready !== 1'b0) begin errors++; $display("FAIL lat_ready_early got %b want 0", Fetch_ready); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL one_outstanding got %b want 0", mem_req); end
        @(negedge clk);
        checks++; if (Fetch_ready !== 1'b1) begin errors++; $display("FAIL lat_ready got %b want 1", Fetch_ready); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL head_pc got %h want 0", instr_pc); end
        checks++; if (instruction !== tag(32'h0)) begin errors++; $display("FAIL head_instr got %h want %h", instruction, tag(32'h0)); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin errors++; $display("FAIL next_req got %b/%h want 1/4", mem_req, mem_addr); end
        pop_pc.delete();
        pop_ins.delete();
        observe(12);
        checks++;
        if (pop_pc.size() < 5) begin
            errors++; $display("FAIL stream_pops got %0d want >=5", pop_pc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (pop_pc[i] !== 32'(4 * (i + 1))) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, pop_pc[i], 32'(4 * (i + 1))); end
                checks++; if (pop_ins[i] !== tag(32'(4 * (i + 1)))) begin errors++; $display("FAIL stream_ins[%0d] got %h want %h", i, pop_ins[i], tag(32'(4 * (i + 1)))); end
            end
        end
    endtask

    task automatic test_stall();
        drive_edge();
        rst   = 1'b1;
        stall = 1'b1;
        drive_edge();
        rst = 1'b0;
        iss_q.delete();
        repeat (20) @(negedge clk);
        checks++;
        if (iss_q.size() != 4) begin
            errors++; $display("FAIL stall_issues got %0d want 4", iss_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (iss_q[i] !== 32'(4 * i)) begin errors++; $display("FAIL stall_addr[%0d] got %h want %h", i, iss_q[i], 32'(4 * i)); end
            end
        end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_no_req got %b want 0", mem_req); end
        checks++; if (Fetch_ready !== 1'b1) begin errors++; $display("FAIL full_ready got %b want 1", Fetch_ready); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL full_head got %h want 0", instr_pc); end
        drive_edge();
        stall = 1'b0;
        pop_pc.delete();
        pop_ins.delete();
        observe(16);
        checks++;
        if (pop_pc.size() < 5) begin
            errors++; $display("FAIL drain_pops got %0d want >=5", pop_pc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (pop_pc[i] !== 32'(4 * i)) begin errors++; $display("FAIL drain_pc[%0d] got %h want %h", i, pop_pc[i], 32'(4 * i)); end
            end
        end
        checks++;
        if (iss_q.size() < 5) begin
            errors++; $display("FAIL resume_issues got %0d want >=5", iss_q.size());
        end else if (iss_q[4] !== 32'h10) begin
            errors++; $display("FAIL resume_addr got %h want 00000010", iss_q[4]);
        end
    endtask

    task automatic test_redirect();
        bit ok;
        drive_edge();
        rst     = 1'b1;
        stall   = 1'b1;
        mem_lat = 1;
        drive_edge();
        rst = 1'b0;
        iss_q.delete();
        wait_iss(2, ok);
        mem_lat = 3;
        if (ok) wait_iss(3, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL redir_setup got timeout want 3 issues"); end
        checks++; if (Fetch_ready !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL redir_pre got %b/%h want 1/0", Fetch_ready, instr_pc); end
        drive_edge();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL redir_no_req got %b want 0", mem_req); end
        drive_edge();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        mem_lat        = 1;
        @(negedge clk);
        checks++; if (Fetch_ready !== 1'b0) begin errors++; $display("FAIL redir_flush got %b want 0", Fetch_ready); end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Fetch_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL redir_refill got timeout want ready"); end
        checks++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL redir_pc got %h want 00000100", instr_pc); end
        checks++; if (instruction !== tag(32'h100)) begin errors++; $display("FAIL redir_ins got %h want %h", instruction, tag(32'h100)); end
        checks++;
        if (iss_q.size() < 4) begin
            errors++; $display("FAIL redir_issues got %0d want >=4", iss_q.size());
        end else if (iss_q[3] !== 32'h100) begin
            errors++; $display("FAIL redir_addr got %h want 00000100", iss_q[3]);
        end
    endtask

    task automatic test_fault();
        int n0;
        drive_edge();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        @(negedge clk);
        n0 = iss_q.size();
        drive_edge();
        redirect_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_set got %b want 1", fetch_fault); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fault_no_req got %b want 0", mem_req); end
        checks++; if (iss_q.size() != n0) begin errors++; $display("FAIL fault_issues got %0d want %0d", iss_q.size(), n0); end
        checks++; if (Fetch_ready !== 1'b0) begin errors++; $display("FAIL fault_ready got %b want 0", Fetch_ready); end
        drive_edge();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        drive_edge();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %b want 0", fetch_fault); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL fault_resume got %b/%h want 1/00000200", mem_req, mem_addr); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        drive_edge();
        rst   = 1'b1;
        stall = 1'b1;
        drive_edge();
        rst = 1'b0;
        iss_q.delete();
        wait_iss(4, ok);
        checks++; if (ok !== 1'b1 || Fetch_ready !== 1'b1) begin errors++; $display("FAIL mid_setup got %b/%b want 1/1", ok, Fetch_ready); end
        drive_edge();
        rst = 1'b1;
        #1;
        checks++; if (Fetch_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b want 0", Fetch_ready); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_req got %b want 0", mem_req); end
        checks++; if (instruction !== NOP || instr_pc !== 32'h0) begin errors++; $display("FAIL mid_head got %h/%h want %h/0", instruction, instr_pc, NOP); end
        checks++; if (mem_addr !== RESET_PC) begin errors++; $display("FAIL mid_addr got %h want %h", mem_addr, RESET_PC); end
        drive_edge();
        rst   = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin errors++; $display("FAIL mid_restart got %b/%h want 1/%h", mem_req, mem_addr, RESET_PC); end
    endtask

    task automatic test_wrap();
        drive_edge();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        drive_edge();
        redirect_valid = 1'b0;
        iss_q.delete();
        pop_pc.delete();
        pop_ins.delete();
        observe(14);
        checks++;
        if (iss_q.size() < 3) begin
            errors++; $display("FAIL wrap_issues got %0d want >=3", iss_q.size());
        end else begin
            checks++; if (iss_q[0] !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_a0 got %h want fffffff8", iss_q[0]); end
            checks++; if (iss_q[1] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_a1 got %h want fffffffc", iss_q[1]); end
            checks++; if (iss_q[2] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_a2 got %h want 00000000", iss_q[2]); end
        end
        checks++;
        if (pop_pc.size() < 3) begin
            errors++; $display("FAIL wrap_pops got %0d want >=3", pop_pc.size());
        end else begin
            checks++; if (pop_pc[2] !== 32'h0 || pop_ins[2] !== tag(32'h0)) begin errors++; $display("FAIL wrap_pop got %h/%h want 0/%h", pop_pc[2], pop_ins[2], tag(32'h0)); end
            checks++; if (pop_pc[0] !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_pop0 got %h want fffffff8", pop_pc[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_fault();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
